// File: rtl/duck_pkg.sv
// Shared types for the Duck Hunt display path: pattern-generator flash modes
// and the zapper controller state encoding.
package duck_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        BLACK  = 2'd1,
        WHITE  = 2'd2
    } flash_mode_t;

    typedef enum logic [2:0] {
        ZS_IDLE,
        ZS_ARM,
        ZS_BLACK,
        ZS_WHITE,
        ZS_JUDGE,
        ZS_HOLD
    } zap_state_t;

    function automatic flash_mode_t flash_of(zap_state_t s);
        case (s)
            ZS_BLACK: return BLACK;
            ZS_WHITE: return WHITE;
            default:  return NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for a raw pin, with an optional rising-edge strobe
// derived from the synchronized level.
module sync_edge #(
    parameter bit EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    // [0],[1] are the synchronizer; [2] is the previous synced level.
    logic [2:0] sync_pipe;

    always_ff @(posedge clk) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[1:0], d};
    end

    assign q    = sync_pipe[1];
    assign rise = EDGE ? (sync_pipe[1] & ~sync_pipe[2]) : 1'b0;

endmodule

// File: rtl/zapper_ctrl.sv
// One-shot zapper sequencer: trigger pull -> black frame -> white-box frames
// -> hit/miss judgement, advanced by frame_start pulses.
module zapper_ctrl
    import duck_pkg::*;
#(
    parameter int WHITE_FRAMES = 1,
    parameter int LIGHT_MIN    = 16,
    parameter int AMMO         = 3,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       trigger,
    input  logic       light,
    input  logic       reload,
    output logic [1:0] flash_mode,
    output logic       hit,
    output logic       miss,
    output logic [1:0] shots_left,
    output logic       busy
);

    localparam logic [1:0]       AMMO_INIT  = 2'(AMMO);
    localparam logic [3:0]       LAST_FRAME = 4'(WHITE_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W:0]   LMIN       = (CNT_W + 1)'(LIGHT_MIN);

    logic trig_s, trig_rise;
    logic light_s, light_rise_unused;

    sync_edge #(.EDGE(1'b1)) u_trig_sync (
        .clk (clk),
        .rst (rst),
        .d   (trigger),
        .q   (trig_s),
        .rise(trig_rise)
    );

    sync_edge #(.EDGE(1'b0)) u_light_sync (
        .clk (clk),
        .rst (rst),
        .d   (light),
        .q   (light_s),
        .rise(light_rise_unused)
    );

    zap_state_t       state;
    logic [CNT_W-1:0] light_cnt;
    logic [CNT_W-1:0] light_nxt;
    logic [3:0]       frame_cnt;
    logic             tainted;
    logic             scored;

    // The final white-frame cycle is still counted when judging on its frame_start.
    assign light_nxt = (light_s && light_cnt != CNT_MAX) ? light_cnt + CNT_W'(1) : light_cnt;
    assign scored    = !tainted && ({1'b0, light_nxt} >= LMIN);
    assign busy      = (state != ZS_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ZS_IDLE;
            flash_mode <= NORMAL;
            hit        <= 1'b0;
            miss       <= 1'b0;
            shots_left <= AMMO_INIT;
            light_cnt  <= '0;
            frame_cnt  <= '0;
            tainted    <= 1'b0;
        end else begin
            hit        <= 1'b0;
            miss       <= 1'b0;
            flash_mode <= flash_of(state);
            case (state)
                ZS_IDLE: begin
                    // A shot in the same cycle as reload wins; no refill happens.
                    if (trig_rise && shots_left != 2'd0) begin
                        shots_left <= shots_left - 2'd1;
                        state      <= ZS_ARM;
                    end else if (reload) begin
                        shots_left <= AMMO_INIT;
                    end
                end
                ZS_ARM: begin
                    if (frame_start) begin
                        light_cnt <= '0;
                        frame_cnt <= '0;
                        tainted   <= 1'b0;
                        state     <= ZS_BLACK;
                    end
                end
                ZS_BLACK: begin
                    if (light_s)     tainted <= 1'b1;
                    if (frame_start) state   <= ZS_WHITE;
                end
                ZS_WHITE: begin
                    light_cnt <= light_nxt;
                    if (frame_start) begin
                        if (frame_cnt == LAST_FRAME) begin
                            hit   <= scored;
                            miss  <= !scored;
                            state <= ZS_JUDGE;
                        end else begin
                            frame_cnt <= frame_cnt + 4'd1;
                        end
                    end
                end
                ZS_JUDGE: state <= ZS_HOLD;
                ZS_HOLD:  if (!trig_s) state <= ZS_IDLE;
                default:  state <= ZS_IDLE;
            endcase
        end
    end

endmodule
